// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The memory handshake and all datapath selects/enables travel here.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       ResultSrc;
  logic [1:0]       ImmSrc;
  logic             illegal_instr;
  logic             retire;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, AdrSrc, MemWrite,
    output IRWrite, PCWrite, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp,
    output ResultSrc, ImmSrc,
    output illegal_instr, retire, instret
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, AdrSrc, MemWrite,
    input  IRWrite, PCWrite, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp,
    input  ResultSrc, ImmSrc,
    input  illegal_instr, retire, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core.
// Sequences fetch, decode, execute, memory and writeback steps.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;

  logic       mem_req, adr_src, mem_write;
  logic       ir_write, pc_write, reg_write;
  logic       retire;
  logic [1:0] src_a, src_b, alu_op;
  logic [1:0] res_src, imm_src;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Next state and Moore outputs, with handshake qualifiers
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    adr_src   = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    retire    = 1'b0;
    src_a     = 2'b00;
    src_b     = 2'b00;
    alu_op    = 2'b00;
    res_src   = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        src_b    = 2'b10;
        res_src  = 2'b10;
        ir_write = bus.mem_ready;
        pc_write = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
        if (bus.op == OP_LW) state_d = S_MEMREAD;
        else                 state_d = S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_src   = 2'b01;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        retire    = bus.mem_ready;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        src_a    = 2'b10;
        alu_op   = 2'b01;
        pc_write = bus.zero;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        src_a    = 2'b01;
        src_b    = 2'b10;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      default: state_d = S_ILLEGAL;
    endcase
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

  // Immediate format follows the opcode directly
  always_comb begin
    imm_src = 2'b00;
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign bus.mem_req       = mem_req;
  assign bus.AdrSrc        = adr_src;
  assign bus.MemWrite      = mem_write;
  assign bus.IRWrite       = ir_write;
  assign bus.PCWrite       = pc_write;
  assign bus.RegWrite      = reg_write;
  assign bus.retire        = retire;
  assign bus.ALUSrcA       = src_a;
  assign bus.ALUSrcB       = src_b;
  assign bus.ALUOp         = alu_op;
  assign bus.ResultSrc     = res_src;
  assign bus.ImmSrc        = imm_src;
  assign bus.illegal_instr = illegal_q;
  assign bus.instret       = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: cycle vectors plus
// a stalled-store sequence; a 4-bit instance checks wrap.
module tb_multicycle_controller;

  logic clk;
  logic reset;

  multicycle_controller_if #(.CNT_W(32)) bus ();
  multicycle_controller_if #(.CNT_W(4))  bus4 ();

  multicycle_controller #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  multicycle_controller #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.master)
  );

  assign bus4.op        = bus.op;
  assign bus4.zero      = bus.zero;
  assign bus4.mem_ready = bus.mem_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] B  = 7'b1100011;
  localparam logic [6:0] J  = 7'b1101111;
  localparam logic [6:0] X  = 7'b1111111;

  // {mem_req,AdrSrc,MemWrite,IRWrite,PCWrite,RegWrite,retire,
  //  ALUSrcA,ALUSrcB,ALUOp,ResultSrc}
  localparam logic [14:0] C_RST  = {7'b0000000, 8'b00_10_00_10};
  localparam logic [14:0] C_FRDY = {7'b1001100, 8'b00_10_00_10};
  localparam logic [14:0] C_FSTL = {7'b1000000, 8'b00_10_00_10};
  localparam logic [14:0] C_DEC  = {7'b0000000, 8'b01_01_00_00};
  localparam logic [14:0] C_MADR = {7'b0000000, 8'b10_01_00_00};
  localparam logic [14:0] C_MRD  = {7'b1100000, 8'b00_00_00_00};
  localparam logic [14:0] C_MWB  = {7'b0000011, 8'b00_00_00_01};
  localparam logic [14:0] C_MWS  = {7'b1110000, 8'b00_00_00_00};
  localparam logic [14:0] C_MWR  = {7'b1110001, 8'b00_00_00_00};
  localparam logic [14:0] C_EXR  = {7'b0000000, 8'b10_00_10_00};
  localparam logic [14:0] C_EXI  = {7'b0000000, 8'b10_01_10_00};
  localparam logic [14:0] C_AWB  = {7'b0000011, 8'b00_00_00_00};
  localparam logic [14:0] C_BQ1  = {7'b0000101, 8'b10_00_01_00};
  localparam logic [14:0] C_BQ0  = {7'b0000001, 8'b10_00_01_00};
  localparam logic [14:0] C_JAL  = {7'b0000100, 8'b01_10_00_00};
  localparam logic [14:0] C_NONE = {7'b0000000, 8'b00_00_00_00};
  localparam logic [14:0] C_MRRS = {7'b0100000, 8'b00_00_00_00};

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [14:0] ctl;
    logic [1:0]  imm;
    logic        ill;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_chk;
  int   n_pass;
  int   n;

  task automatic add(input logic r, input logic [6:0] o,
                     input logic z, input logic rd,
                     input logic [14:0] c, input logic [1:0] im,
                     input logic il, input int cn);
    vec_t v;
    v.rst = r;  v.op  = o;  v.z   = z;  v.rdy = rd;
    v.ctl = c;  v.imm = im; v.ill = il; v.cnt = cn;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [14:0] ctl_now();
    return {bus.mem_req, bus.AdrSrc, bus.MemWrite,
            bus.IRWrite, bus.PCWrite, bus.RegWrite,
            bus.retire, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUOp, bus.ResultSrc};
  endfunction

  task automatic apply(input vec_t v, input int idx);
    logic [3:0] c4;
    c4 = v.cnt[3:0];
    reset         = v.rst;
    bus.op        = v.op;
    bus.zero      = v.z;
    bus.mem_ready = v.rdy;
    #3;
    chk("ctl", idx, 32'(ctl_now()), 32'(v.ctl));
    chk("imm", idx, 32'(bus.ImmSrc), 32'(v.imm));
    chk("ill", idx, 32'(bus.illegal_instr), 32'(v.ill));
    chk("cnt", idx, bus.instret, v.cnt);
    chk("cnt4", idx, 32'(bus4.instret), 32'(c4));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, mw, rw;
    logic got;
    n_chk  = 0;
    n_pass = 0;
    n      = 0;
    reset         = 1'b1;
    bus.op        = R;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    add(1, R, 0, 1, C_RST, 2'b00, 0, n);
    // R-type
    add(0, R, 0, 1, C_FRDY, 2'b00, 0, n);
    add(0, R, 0, 1, C_DEC,  2'b00, 0, n);
    add(0, R, 0, 1, C_EXR,  2'b00, 0, n);
    add(0, R, 0, 1, C_AWB,  2'b00, 0, n);
    n++;
    // lw, 2 fetch stalls and 3 read stalls
    add(0, LW, 0, 0, C_FSTL, 2'b00, 0, n);
    add(0, LW, 0, 0, C_FSTL, 2'b00, 0, n);
    add(0, LW, 0, 1, C_FRDY, 2'b00, 0, n);
    add(0, LW, 0, 1, C_DEC,  2'b00, 0, n);
    add(0, LW, 0, 1, C_MADR, 2'b00, 0, n);
    for (int i = 0; i < 3; i++)
      add(0, LW, 0, 0, C_MRD, 2'b00, 0, n);
    add(0, LW, 0, 1, C_MRD,  2'b00, 0, n);
    add(0, LW, 0, 1, C_MWB,  2'b00, 0, n);
    n++;
    // sw, one write stall
    add(0, SW, 0, 1, C_FRDY, 2'b01, 0, n);
    add(0, SW, 0, 1, C_DEC,  2'b01, 0, n);
    add(0, SW, 0, 1, C_MADR, 2'b01, 0, n);
    add(0, SW, 0, 0, C_MWS,  2'b01, 0, n);
    add(0, SW, 0, 1, C_MWR,  2'b01, 0, n);
    n++;
    // beq taken then not taken
    add(0, B, 1, 1, C_FRDY, 2'b10, 0, n);
    add(0, B, 1, 1, C_DEC,  2'b10, 0, n);
    add(0, B, 1, 1, C_BQ1,  2'b10, 0, n);
    n++;
    add(0, B, 0, 1, C_FRDY, 2'b10, 0, n);
    add(0, B, 0, 1, C_DEC,  2'b10, 0, n);
    add(0, B, 0, 1, C_BQ0,  2'b10, 0, n);
    n++;
    // I-type
    add(0, IT, 0, 1, C_FRDY, 2'b00, 0, n);
    add(0, IT, 0, 1, C_DEC,  2'b00, 0, n);
    add(0, IT, 0, 1, C_EXI,  2'b00, 0, n);
    add(0, IT, 0, 1, C_AWB,  2'b00, 0, n);
    n++;
    // jal
    add(0, J, 0, 1, C_FRDY, 2'b11, 0, n);
    add(0, J, 0, 1, C_DEC,  2'b11, 0, n);
    add(0, J, 0, 1, C_JAL,  2'b11, 0, n);
    add(0, J, 0, 1, C_AWB,  2'b11, 0, n);
    n++;
    // illegal opcode, absorbing
    add(0, X, 0, 1, C_FRDY, 2'b00, 0, n);
    add(0, X, 0, 1, C_DEC,  2'b00, 0, n);
    for (int i = 0; i < 20; i++)
      add(0, X, i[0], 1, C_NONE, 2'b00, 1, n);
    add(1, X, 0, 1, C_NONE, 2'b00, 1, n);
    n = 0;
    add(0, R, 0, 1, C_FRDY, 2'b00, 0, n);
    add(0, R, 0, 1, C_DEC,  2'b00, 0, n);
    add(0, R, 0, 1, C_EXR,  2'b00, 0, n);
    add(0, R, 0, 1, C_AWB,  2'b00, 0, n);
    n++;
    // reset while in MEMREAD
    add(0, LW, 0, 1, C_FRDY, 2'b00, 0, n);
    add(0, LW, 0, 1, C_DEC,  2'b00, 0, n);
    add(0, LW, 0, 1, C_MADR, 2'b00, 0, n);
    add(0, LW, 0, 0, C_MRD,  2'b00, 0, n);
    add(1, LW, 0, 1, C_MRRS, 2'b00, 0, n);
    n = 0;
    add(0, R, 0, 0, C_FSTL, 2'b00, 0, n);
    // 16 retires for the 4-bit counter wrap
    for (int i = 0; i < 16; i++) begin
      add(0, B, 0, 1, C_FRDY, 2'b10, 0, n);
      add(0, B, 0, 1, C_DEC,  2'b10, 0, n);
      add(0, B, 0, 1, C_BQ0,  2'b10, 0, n);
      n++;
    end
    add(1, B, 0, 1, C_RST, 2'b10, 0, n);

    foreach (tbl[i]) apply(tbl[i], i);

    // sw with a random-length write stall
    reset         = 1'b0;
    bus.op        = SW;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    k   = $urandom_range(1, 5);
    mw  = 0;
    rw  = 0;
    got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus.mem_ready = (c >= k);
      #3;
      if (bus.MemWrite) mw++;
      if (bus.RegWrite) rw++;
      if (bus.retire) got = 1'b1;
      @(posedge clk);
      #1;
      if (got) break;
    end
    bus.mem_ready = 1'b1;
    #3;
    chk("sw_retire", k, 32'(got), 32'd1);
    chk("sw_mw_len", k, mw, k + 1);
    chk("sw_regwr", k, rw, 0);
    chk("sw_instret", k, bus.instret, 32'd1);
    chk("sw_fetch", k, 32'(ctl_now()), 32'(C_FRDY));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
